mux_serializer_ctrl: RTL and testbench



---
 rtl/mux_serializer_ctrl.sv | 113 +++++++++++
 tb/tb_mux_serializer_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mux_serializer_ctrl.sv
// mux_serializer_ctrl: upstream sequencer for the 8:1 bit mux.
// Accepts 8-bit words over valid/ready. Holds each word on mux_in and
// steps mux_sel through all bit positions, one per consumed bit, with
// first/last framing and busy status for the consumer of the mux output.
module mux_serializer_ctrl #(
  parameter bit LSB_FIRST = 1'b1,
  parameter int WIDTH     = 8,
  parameter int SEL_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] mux_in,
  output logic [SEL_W-1:0] mux_sel,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             first,
  output logic             last,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Select value for bit 0 of a frame, and the counter value of the final bit.
  localparam logic [SEL_W-1:0] START    = LSB_FIRST ? '0 : SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] LAST_CNT = SEL_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mux_in_q, mux_in_d;
  logic [SEL_W-1:0] mux_sel_q, mux_sel_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;

  logic in_shift;
  logic accept;
  logic bit_hs;

  // Output decode: everything comes from state/count, except that din_ready
  // also looks at bit_ready so a new word can be taken on the last bit.
  always_comb begin
    in_shift  = (state_q == SHIFT);
    bit_valid = in_shift;
    busy      = in_shift;
    first     = in_shift && (cnt_q == '0);
    last      = in_shift && (cnt_q == LAST_CNT);
    din_ready = !in_shift || (last && bit_ready);
    accept    = din_valid && din_ready;
    bit_hs    = in_shift && bit_ready;
  end

  // Next-state logic: load on accept, step on each bit handshake, hold on stall.
  always_comb begin
    // NOTE: every signal written here gets a default first so that paths
    // which do not assign it fall back to "hold" instead of inferring a latch.
    state_d   = state_q;
    mux_in_d  = mux_in_q;
    mux_sel_d = mux_sel_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          mux_in_d  = din;
          mux_sel_d = START;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_hs) begin
          if (cnt_q != LAST_CNT) begin
            cnt_d     = cnt_q + SEL_W'(1);
            mux_sel_d = LSB_FIRST ? mux_sel_q + SEL_W'(1) : mux_sel_q - SEL_W'(1);
          end else if (din_valid) begin
            // Back-to-back word: reload without a bubble cycle.
            mux_in_d  = din;
            mux_sel_d = START;
            cnt_d     = '0;
          end else begin
            // Frame done; mux_in keeps the old word.
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample their _d values from the same pre-edge snapshot.
    if (!rst_n) begin
      state_q   <= IDLE;
      mux_in_q  <= '0;
      mux_sel_q <= START;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mux_in_q  <= mux_in_d;
      mux_sel_q <= mux_sel_d;
      cnt_q     <= cnt_d;
    end
  end

  assign mux_in  = mux_in_q;
  assign mux_sel = mux_sel_q;

endmodule

// File: tb/tb_mux_serializer_ctrl.sv
// tb_mux_serializer_ctrl: drives an LSB-first and an MSB-first instance
// with identical stimulus and compares both against a transaction-level
// model (current word, bit index within frame, frame-active flag).
module tb_mux_serializer_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       bit_ready;

  logic       l_din_ready, l_bit_valid, l_first, l_last, l_busy;
  logic [7:0] l_mux_in;
  logic [2:0] l_mux_sel;
  logic       m_din_ready, m_bit_valid, m_first, m_last, m_busy;
  logic [7:0] m_mux_in;
  logic [2:0] m_mux_sel;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [7:0] ref_word;
  int         ref_k;
  bit         ref_active;

  mux_serializer_ctrl #(.LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(l_din_ready), .mux_in(l_mux_in), .mux_sel(l_mux_sel),
    .bit_valid(l_bit_valid), .bit_ready(bit_ready), .first(l_first),
    .last(l_last), .busy(l_busy)
  );

  mux_serializer_ctrl #(.LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(m_din_ready), .mux_in(m_mux_in), .mux_sel(m_mux_sel),
    .bit_valid(m_bit_valid), .bit_ready(bit_ready), .first(m_first),
    .last(m_last), .busy(m_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    ref_word   = 8'h00;
    ref_k      = 0;
    ref_active = 1'b0;
  endtask

  // Outputs expected while in reset: idle, START select, cleared word.
  task automatic check_reset_values();
    check("rst_l_valid", {31'd0, l_bit_valid}, 0);
    check("rst_l_busy",  {31'd0, l_busy}, 0);
    check("rst_l_first", {31'd0, l_first}, 0);
    check("rst_l_last",  {31'd0, l_last}, 0);
    check("rst_l_sel",   {29'd0, l_mux_sel}, 0);
    check("rst_l_in",    {24'd0, l_mux_in}, 0);
    check("rst_m_valid", {31'd0, m_bit_valid}, 0);
    check("rst_m_busy",  {31'd0, m_busy}, 0);
    check("rst_m_sel",   {29'd0, m_mux_sel}, 7);
    check("rst_m_in",    {24'd0, m_mux_in}, 0);
  endtask

  // Compare both instances against the model in the current cycle.
  task automatic compare_all();
    logic exp_ready, exp_first, exp_last;
    logic [2:0] lsel, msel;
    exp_ready = !ref_active || (ref_k == 7 && bit_ready);
    exp_first = ref_active && ref_k == 0;
    exp_last  = ref_active && ref_k == 7;
    check("l_valid", {31'd0, l_bit_valid}, {31'd0, ref_active});
    check("l_busy",  {31'd0, l_busy}, {31'd0, ref_active});
    check("l_first", {31'd0, l_first}, {31'd0, exp_first});
    check("l_last",  {31'd0, l_last}, {31'd0, exp_last});
    check("l_ready", {31'd0, l_din_ready}, {31'd0, exp_ready});
    check("l_mux_in", {24'd0, l_mux_in}, {24'd0, ref_word});
    check("m_valid", {31'd0, m_bit_valid}, {31'd0, ref_active});
    check("m_busy",  {31'd0, m_busy}, {31'd0, ref_active});
    check("m_first", {31'd0, m_first}, {31'd0, exp_first});
    check("m_last",  {31'd0, m_last}, {31'd0, exp_last});
    check("m_ready", {31'd0, m_din_ready}, {31'd0, exp_ready});
    check("m_mux_in", {24'd0, m_mux_in}, {24'd0, ref_word});
    if (ref_active) begin
      lsel = l_mux_sel;
      msel = m_mux_sel;
      check("l_sel", {29'd0, lsel}, ref_k);
      check("m_sel", {29'd0, msel}, 7 - ref_k);
      check("l_serial", {31'd0, l_mux_in[lsel]}, {31'd0, ref_word[ref_k]});
      check("m_serial", {31'd0, m_mux_in[msel]}, {31'd0, ref_word[7 - ref_k]});
    end
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_edge(input logic [7:0] d, input logic dv, input logic br);
    bit ready_now;
    ready_now = !ref_active || (ref_k == 7 && br);
    if (ref_active && br) begin
      if (ref_k == 7) ref_active = 1'b0;
      else ref_k++;
    end
    if (dv && ready_now) begin
      ref_word   = d;
      ref_k      = 0;
      ref_active = 1'b1;
    end
  endtask

  // One cycle: drive after the falling edge, check, then cross the rising edge.
  task automatic step(input logic [7:0] d, input logic dv, input logic br);
    din       = d;
    din_valid = dv;
    bit_ready = br;
    #1;
    compare_all();
    @(posedge clk);
    model_edge(d, dv, br);
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;
    bit_ready = 1'b0;
    model_reset();
    #12;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("l_ready_after_rst", {31'd0, l_din_ready}, 1);

    // Single word 0xA5, LSB and MSB orders, bit_ready tied high.
    step(8'hA5, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);

    // MSB-order word 0xC1 (also checked on the LSB instance).
    step(8'hC1, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) step(8'h00, 1'b0, 1'b1);

    // Back-to-back 0x01 then 0x80 with din_valid held high.
    step(8'h01, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(8'h80, 1'b1, 1'b1);
    check("b2b_ready_on_last", {31'd0, l_din_ready & l_last}, 1);
    step(8'h80, 1'b1, 1'b1);
    check("b2b_reload", {24'd0, l_mux_in}, 8'h80);
    for (int i = 0; i < 8; i++) step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);

    // Stall for 3 cycles at bit 4 of 0x3C.
    step(8'h3C, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b0);
    check("stall_sel_hold", {29'd0, l_mux_sel}, 4);
    for (int i = 0; i < 5; i++) step(8'h00, 1'b0, 1'b1);

    // Busy-time input toggling must not disturb the frame.
    step(8'h5A, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(8'($urandom), 1'($urandom), 1'b1);
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);

    // Reset asserted between edges while the frame sits at bit 5.
    step(8'hE7, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(8'h00, 1'b0, 1'b1);
    din = 8'h00; din_valid = 1'b0; bit_ready = 1'b1;
    #1;
    compare_all();
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b1);

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 2000; i++)
      step(8'($urandom), ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
